div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//  Iterative radix-2 restoring divider for MIPS DIV/DIVU.
//  Produces quotient (LO) and remainder (HI).
//  These feed the writeback-select mux2 that chooses between ALU and HI/LO results.
//  Sits in EX; the pipeline stalls on busy and flushes it with cancel on exceptions.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; iteration count = WIDTH
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  start      in   1      launch a division; sampled only in IDLE
//  sign       in   1      1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
//  cancel     in   1      abort the in-flight division (pipeline flush)
//  dividend   in   WIDTH  numerator; sampled with start
//  divisor    in   WIDTH  denominator; sampled with start
//  busy       out  1      1 while in BUSY or DONE; stall request to the pipeline
//  done       out  1      one-cycle pulse; quotient/remainder valid from this cycle on
//  quotient   out  WIDTH  result quotient (to LO)
//  remainder  out  WIDTH  result remainder (to HI)
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, quotient=0, remainder=0.
//    Reset overrides every other input, including mid-division.
//  FSM (registered):
//    IDLE -> BUSY on start & !cancel.
//      At this edge: latch |dividend|, |divisor|, sign flags; clear iteration counter.
//    BUSY: one restoring step per cycle.
//      Shift {rem,quo} left 1; trial = rem - divisor; if no borrow keep it and set quo[0].
//      Counter counts 0..WIDTH-1. After step WIDTH-1 -> DONE.
//    DONE: quotient/remainder registers updated (sign-corrected); done=1 for this
//      single cycle; -> IDLE next edge.
//    cancel in BUSY or DONE -> IDLE next edge.
//      On cancel, done is never raised (or is dropped) and quotient/remainder keep
//      their prior values.
//  Latency: start sampled at edge E -> done=1 in the cycle after edge E+WIDTH+1
//    (33 edges for WIDTH=32). busy=1 from edge E through the done cycle.
//  start while busy=1: ignored, no queuing.
//  start & cancel same cycle in IDLE: cancel wins, nothing launched.
//  Outputs hold the last completed result indefinitely until the next completion.
//  Signed mode: operate on magnitudes; quotient negated iff operand signs differ.
//    Remainder takes the sign of the dividend. Magnitude of most-negative value is
//    treated as unsigned 2^(WIDTH-1).
//  Overflow: signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
//  Divisor 0 (either mode): quotient = all ones, remainder = original dividend.
//    Same latency; no exception raised.
//  Unsigned mode: no sign processing; the full WIDTH-bit range is valid.
//  All arithmetic is WIDTH bits; the trial subtraction uses WIDTH+1 bits for borrow.
// TESTING
//  1. DIVU 100 / 7 -> done exactly 33 cycles after start; Q=14, R=2; busy high throughout.
//  2. DIV -7 / 2 -> Q=0xFFFFFFFD (-3), R=0xFFFFFFFF (-1); DIV 7 / -2 -> Q=-3, R=1.
//  3. DIV 0x80000000 / 0xFFFFFFFF -> Q=0x80000000, R=0.
//     DIVU 0xFFFFFFFF / 1 -> Q=0xFFFFFFFF, R=0.
//  4. DIVU 5 / 0 -> Q=0xFFFFFFFF, R=5.
//     DIV -5 / 0 -> Q=0xFFFFFFFF, R=0xFFFFFFFB.
//  5. Cancel: start 100/7, pulse cancel at cycle 10 -> idle next cycle, done never
//     pulses, Q/R keep prior result. A second start during busy is ignored.
//  6. Reset: assert rst at cycle 15 of a division -> busy=0, done=0, Q=0, R=0 next
//     cycle; a subsequent start completes normally.

Source files
------------

// File: rtl/div_unit_if.sv
// Divider request/response bundle: the pipeline drives operands and control,
// the divider returns status and the HI/LO results.
interface div_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             sign;
  logic             cancel;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, sign, cancel, dividend, divisor,
    input  busy, done, quotient, remainder
  );

  modport slave (
    input  start, sign, cancel, dividend, divisor,
    output busy, done, quotient, remainder
  );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU.
// Produces the quotient (LO) and remainder (HI); stalls the pipeline via busy.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic  clk,
  input logic  rst,
  div_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic             neg_q_q, neg_r_q, div0_q;
  logic [WIDTH-1:0] res_q_q, res_r_q;
  logic [WIDTH-1:0] q_hold_q, r_hold_q;

  logic [WIDTH:0]   shifted, trial;
  logic             no_borrow;
  logic [WIDTH-1:0] abs_dividend, abs_divisor;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start && !bus.cancel) state_d = BUSY;
      BUSY: begin
        if (bus.cancel)         state_d = IDLE;
        else if (cnt_q == LAST) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    abs_dividend = (bus.sign && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
    abs_divisor  = (bus.sign && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
    shifted      = {rem_q, quo_q[WIDTH-1]};
    trial        = shifted - {1'b0, dvs_q};
    // A set top bit means shifted already exceeds any WIDTH-bit divisor.
    no_borrow    = shifted[WIDTH] || !trial[WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      div0_q   <= 1'b0;
      res_q_q  <= '0;
      res_r_q  <= '0;
      q_hold_q <= '0;
      r_hold_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start && !bus.cancel) begin
            quo_q   <= abs_dividend;
            dvs_q   <= abs_divisor;
            rem_q   <= '0;
            cnt_q   <= '0;
            neg_q_q <= bus.sign && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            neg_r_q <= bus.sign && bus.dividend[WIDTH-1];
            div0_q  <= (bus.divisor == '0);
          end
        end
        BUSY: begin
          if (cnt_q != LAST) begin
            rem_q <= no_borrow ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], no_borrow};
            cnt_q <= cnt_q + CW'(1);
          end else begin
            res_q_q <= div0_q ? '1 : (neg_q_q ? -quo_q : quo_q);
            res_r_q <= neg_r_q ? -rem_q : rem_q;
          end
        end
        DONE: begin
          if (!bus.cancel) begin
            q_hold_q <= res_q_q;
            r_hold_q <= res_r_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Results are staged so a cancel during DONE leaves the visible outputs untouched.
  always_comb begin
    bus.busy      = (state_q != IDLE);
    bus.done      = (state_q == DONE) && !bus.cancel;
    bus.quotient  = bus.done ? res_q_q : q_hold_q;
    bus.remainder = bus.done ? res_r_q : r_hold_q;
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed vectors push expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_div_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned cyc = 0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int unsigned due;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[11] = '{
    '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2},
    '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF},
    '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1},
    '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0},
    '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0},
    '{1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5},
    '{1'b1, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFFB},
    '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE},
    '{1'b0, 32'hFFFFFFFF,   32'h80000001,   32'd1,          32'h7FFFFFFE},
    '{1'b0, 32'h80000000,   32'd3,          32'h2AAAAAAA,   32'd2},
    '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFE,   32'd1,          32'd1}
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_done", {31'd0, bus.done}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", bus.quotient, e.q);
        check("remainder", bus.remainder, e.r);
        check("latency_cycle", cyc, e.due);
      end
    end
  end

  task automatic run_div(input vec_t v, input int unsigned restart_at);
    int unsigned n;
    logic busy_bad;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.sign     = v.sgn;
    bus.dividend = v.a;
    bus.divisor  = v.b;
    sb.push_back('{v.q, v.r, cyc + 34});
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    busy_bad = 1'b0;
    while (bus.done !== 1'b1 && n < 40) begin
      if (bus.busy !== 1'b1) busy_bad = 1'b1;
      @(negedge clk);
      n++;
      if (restart_at != 0 && n == restart_at) begin
        bus.start    = 1'b1;
        bus.dividend = 32'd9;
        bus.divisor  = 32'd3;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    check("busy_during_div", {31'd0, busy_bad}, 32'd0);
    if (n >= 40) check("done_timeout", {31'd0, bus.done}, 32'd1);
    if (bus.done === 1'b1) check("busy_in_done", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    check("done_single_pulse", {31'd0, bus.done}, 32'd0);
    check("idle_after_done", {31'd0, bus.busy}, 32'd0);
    check("hold_quotient", bus.quotient, v.q);
    check("hold_remainder", bus.remainder, v.r);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start    = 1'b0;
    bus.sign     = 1'b0;
    bus.cancel   = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_quotient", bus.quotient, 32'd0);
    check("reset_remainder", bus.remainder, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) run_div(vecs[i], 0);

    // Second start during busy must be ignored.
    run_div(vecs[0], 5);
    repeat (40) @(negedge clk);

    // Cancel mid-division: results keep the 100/7 values.
    bus.start = 1'b1; bus.sign = 1'b0; bus.dividend = 32'd1000; bus.divisor = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    check("cancel_busy", {31'd0, bus.busy}, 32'd0);
    repeat (40) @(negedge clk);
    check("cancel_keep_q", bus.quotient, 32'd14);
    check("cancel_keep_r", bus.remainder, 32'd2);

    // start and cancel together in IDLE launch nothing.
    bus.start = 1'b1; bus.cancel = 1'b1; bus.dividend = 32'd50; bus.divisor = 32'd5;
    @(negedge clk);
    bus.start = 1'b0; bus.cancel = 1'b0;
    check("start_cancel_busy", {31'd0, bus.busy}, 32'd0);
    repeat (40) @(negedge clk);

    // Reset mid-division clears everything.
    bus.start = 1'b1; bus.dividend = 32'd100; bus.divisor = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset_busy", {31'd0, bus.busy}, 32'd0);
    check("midreset_done", {31'd0, bus.done}, 32'd0);
    check("midreset_q", bus.quotient, 32'd0);
    check("midreset_r", bus.remainder, 32'd0);
    repeat (40) @(negedge clk);
    run_div(vecs[1], 0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
